count_display_driver: RTL and testbench

//   Shows the 8-bit LED count as decimal on the board's common-anode 7-segment display.
//   A sequential double-dabble unit converts the binary count to 3 BCD digits.
//   A refresh timer time-multiplexes those digits onto the shared cathodes.

---
 rtl/count_display_driver.sv | 145 ++++++++++++++
 tb/tb_count_display_driver.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/count_display_driver.sv
// count_display_driver: shows an 8-bit count as up to three decimal digits on a
// common-anode 7-segment display. A sequential double-dabble converter turns the
// count into BCD, and a free-running refresh timer scans the digits.
module count_display_driver #(
    parameter int REFRESH_COUNT = 100_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  count,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        busy,
    output logic [11:0] bcd
);

    localparam int RW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
    localparam logic [RW-1:0] RC_LAST = RW'(REFRESH_COUNT - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t      state, state_nx;
    logic [7:0]  shown;
    logic [19:0] shreg;
    logic [2:0]  iter;

    logic [RW-1:0] rcnt;
    logic [1:0]    slot, slot_nx;
    logic [3:0]    digit, an_nx;
    logic [6:0]    seg_nx;
    logic          blank;

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[8+4*i +: 4] >= 4'd5)
                t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    // Active-low cathode pattern for one hex digit (a = bit 0 .. g = bit 6).
    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign busy = (state != IDLE);
    assign dp   = 1'b1;

    // Conversion FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Conversion FSM next state; count is only looked at while idle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (count != shown) state_nx = SHIFT;
            SHIFT:   if (iter == 3'd7)   state_nx = LOAD;
            LOAD:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Conversion datapath; bcd updates only in LOAD so partial results never show.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shown <= 8'd0;
            shreg <= 20'd0;
            iter  <= 3'd0;
            bcd   <= 12'h000;
        end else begin
            case (state)
                IDLE: if (count != shown) begin
                    shown <= count;
                    shreg <= {12'b0, count};
                    iter  <= 3'd0;
                end
                SHIFT: begin
                    shreg <= dd_step(shreg);
                    iter  <= iter + 3'd1;
                end
                LOAD:    bcd <= shreg[19:8];
                default: ;
            endcase
        end
    end

    // Next slot and its anode/cathode pattern, with leading-zero blanking.
    always_comb begin
        slot_nx = slot;
        if (rcnt == RC_LAST) slot_nx = (slot == 2'd2) ? 2'd0 : slot + 2'd1;
        digit = bcd[3:0];
        blank = 1'b0;
        case (slot_nx)
            2'd0: begin digit = bcd[3:0];  blank = 1'b0; end
            2'd1: begin digit = bcd[7:4];  blank = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0); end
            2'd2: begin digit = bcd[11:8]; blank = (bcd[11:8] == 4'd0); end
            default: blank = 1'b1;
        endcase
        an_nx  = ~(4'b0001 << slot_nx);
        seg_nx = hex7(digit);
        if (blank) begin
            an_nx  = 4'b1111;
            seg_nx = 7'b1111111;
        end
    end

    // Refresh timer, slot pointer and registered display outputs; never stalled by busy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rcnt <= '0;
            slot <= 2'd0;
            an   <= 4'b1110;
            seg  <= 7'b1000000;
        end else begin
            rcnt <= (rcnt == RC_LAST) ? '0 : rcnt + RW'(1);
            slot <= slot_nx;
            an   <= an_nx;
            seg  <= seg_nx;
        end
    end

endmodule

// File: tb/tb_count_display_driver.sv
// Bench for count_display_driver with a short refresh period.
module tb_count_display_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  count = 8'd0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;
    logic [11:0] bcd;

    int errors = 0;
    int checks = 0;
    int ecnt;
    logic [11:0] sb[$];
    logic [11:0] last_bcd;

    typedef struct {
        logic [7:0]  c;
        logic [11:0] b;
        logic [11:0] an3;  // {slot2, slot1, slot0}
        logic [20:0] sg3;  // {slot2, slot1, slot0}
    } vec_t;
    vec_t vt[7];

    count_display_driver #(.REFRESH_COUNT(4)) dut (
        .clk(clk), .reset(reset), .count(count), .an(an), .seg(seg),
        .dp(dp), .busy(busy), .bcd(bcd)
    );

    always #5 clk = ~clk;

    // Edges since reset release; slot after edge n is (n/4)%3.
    always @(posedge clk or negedge reset) begin
        if (!reset) ecnt <= 0;
        else        ecnt <= ecnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic busy_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("busy_high", 32'(busy), 32'd1);
            chk("bcd_hold", 32'(bcd), 32'(last_bcd));
        end
    endtask

    task automatic finish_conv();
        logic [11:0] e;
        @(negedge clk);
        chk("busy_low", 32'(busy), 32'd0);
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("bcd_result", 32'(bcd), 32'(e));
            last_bcd = e;
        end
    endtask

    task automatic scan_check(input vec_t v);
        int s;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            s = (ecnt / 4) % 3;
            chk("scan_an", 32'(an), 32'(v.an3[s*4 +: 4]));
            chk("scan_seg", 32'(seg), 32'(v.sg3[s*7 +: 7]));
        end
    endtask

    initial begin
        vt[0] = '{8'd7,   12'h007, {4'b1111, 4'b1111, 4'b1110}, {7'b1111111, 7'b1111111, 7'b1111000}};
        vt[1] = '{8'd105, 12'h105, {4'b1011, 4'b1101, 4'b1110}, {7'b1111001, 7'b1000000, 7'b0010010}};
        vt[2] = '{8'd255, 12'h255, {4'b1011, 4'b1101, 4'b1110}, {7'b0100100, 7'b0010010, 7'b0010010}};
        vt[3] = '{8'd0,   12'h000, {4'b1111, 4'b1111, 4'b1110}, {7'b1111111, 7'b1111111, 7'b1000000}};
        vt[4] = '{8'd40,  12'h040, {4'b1111, 4'b1101, 4'b1110}, {7'b1111111, 7'b0011001, 7'b1000000}};
        vt[5] = '{8'd198, 12'h198, {4'b1011, 4'b1101, 4'b1110}, {7'b1111001, 7'b0010000, 7'b0000000}};
        vt[6] = '{8'd63,  12'h063, {4'b1111, 4'b1101, 4'b1110}, {7'b1111111, 7'b0000010, 7'b0110000}};

        // Reset held low for 5 clocks.
        #2 reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_an", 32'(an), 32'b1110);
        chk("rst_seg", 32'(seg), 32'b1000000);
        chk("rst_bcd", 32'(bcd), 32'h000);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dp", 32'(dp), 32'd1);
        reset = 1'b1;
        last_bcd = 12'h000;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Table: convert each value, check latency/result, then the scan pattern.
        foreach (vt[i]) begin
            count = vt[i].c;
            sb.push_back(vt[i].b);
            busy_cycles(9);
            finish_conv();
            repeat (3) @(negedge clk);
            scan_check(vt[i]);
        end

        // count changes mid-conversion: first result 010, then a second pass to 200.
        count = 8'd10;
        sb.push_back(12'h010);
        busy_cycles(3);
        count = 8'd200;
        sb.push_back(12'h200);
        busy_cycles(6);
        finish_conv();
        busy_cycles(9);
        finish_conv();

        // Reset during a conversion of 99 discards it; fresh conversion after release.
        count = 8'd99;
        sb.push_back(12'h099);
        busy_cycles(4);
        reset = 1'b0;
        #1;
        chk("midrst_bcd", 32'(bcd), 32'h000);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_an", 32'(an), 32'b1110);
        chk("midrst_seg", 32'(seg), 32'b1000000);
        sb.delete();
        last_bcd = 12'h000;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sb.push_back(12'h099);
        busy_cycles(9);
        finish_conv();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
